// File: rtl/hazard_scoreboard.sv
// Load-use / multi-cycle-result hazard controller sitting beside the ID stage.
// Tracks per-register cycles-until-forwardable and stalls IF/ID with EX bubbles
// until every source operand of the ID instruction is reachable by forwarding.
module hazard_scoreboard #(
  parameter int unsigned LAT_LOAD = 1,
  parameter int unsigned LAT_MUL  = 2,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       id_rd,
  input  logic             id_reg_write,
  input  logic [1:0]       id_class,
  input  logic             branch_taken_ex,
  input  logic             freeze,
  output logic             stall_if,
  output logic             stall_id,
  output logic             bubble_ex,
  output logic             flush_id,
  output logic [CNT_W-1:0] stall_count
);

  localparam int unsigned NREG  = 32;
  localparam int unsigned LAT_W = 2;

  localparam logic [1:0] CLS_LOAD = 2'b01;
  localparam logic [1:0] CLS_MUL  = 2'b10;

  logic [LAT_W-1:0] cnt_q [NREG];
  logic [LAT_W-1:0] cnt_d [NREG];
  logic [CNT_W-1:0] count_q;
  logic [LAT_W-1:0] lat;
  logic             hazard;
  logic             issue;
  logic             count_en;

  // Source operand still waiting on an in-flight producer (x0 never waits)
  always_comb begin
    hazard = id_valid &&
             ((id_use_rs1 && (id_rs1 != 5'd0) && (cnt_q[id_rs1] != '0)) ||
              (id_use_rs2 && (id_rs2 != 5'd0) && (cnt_q[id_rs2] != '0)));
    issue    = id_valid && !freeze && !branch_taken_ex && !hazard;
    count_en = hazard && !freeze && !branch_taken_ex;
  end

  // Result latency of the issuing instruction's class (class 11 behaves as ALU)
  always_comb begin
    lat = '0;
    case (id_class)
      CLS_LOAD: lat = LAT_W'(LAT_LOAD);
      CLS_MUL:  lat = LAT_W'(LAT_MUL);
      default:  lat = '0;
    endcase
  end

  // Next scoreboard: count everything down, then a new producer overwrites its rd
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      cnt_d[i] = cnt_q[i];
      if (cnt_q[i] != '0) cnt_d[i] = cnt_q[i] - LAT_W'(1);
    end
    if (issue && id_reg_write && (id_rd != 5'd0)) cnt_d[id_rd] = lat;
    cnt_d[0] = '0;
  end

  // Scoreboard and stall counter state; both hold during an external freeze
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < NREG; i++) cnt_q[i] <= '0;
      count_q <= '0;
    end else if (!freeze) begin
      for (int i = 0; i < NREG; i++) cnt_q[i] <= cnt_d[i];
      if (count_en && (count_q != '1)) count_q <= count_q + CNT_W'(1);
    end
  end

  // Pipeline control by priority freeze > taken branch > hazard; quiet in reset
  always_comb begin
    stall_if    = 1'b0;
    stall_id    = 1'b0;
    bubble_ex   = 1'b0;
    flush_id    = 1'b0;
    stall_count = '0;
    if (rstn) begin
      stall_count = count_q;
      if (freeze) begin
        stall_if = 1'b1;
        stall_id = 1'b1;
      end else if (branch_taken_ex) begin
        flush_id  = 1'b1;
        bubble_ex = 1'b1;
      end else if (hazard) begin
        stall_if  = 1'b1;
        stall_id  = 1'b1;
        bubble_ex = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed scenarios with literal
// expectations plus a randomized run compared every cycle against a register
// table model. A narrow-counter instance exercises saturation cheaply.
module tb_hazard_scoreboard;

  logic        clk;
  logic        rstn;
  logic        id_valid;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_use_rs1, id_use_rs2, id_reg_write;
  logic [1:0]  id_class;
  logic        branch_taken_ex, freeze;

  logic        stall_if, stall_id, bubble_ex, flush_id;
  logic [15:0] stall_count;
  logic        s_stall_if, s_stall_id, s_bubble_ex, s_flush_id;
  logic [3:0]  s_stall_count;

  int errors = 0;
  int checks = 0;

  // Reference model: remaining cycles per register and expected counters
  int mcnt [32];
  int mcount;
  int mcount_small;

  hazard_scoreboard #(.LAT_LOAD(1), .LAT_MUL(2), .CNT_W(16)) dut (
    .clk(clk), .rstn(rstn), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_class(id_class),
    .branch_taken_ex(branch_taken_ex), .freeze(freeze),
    .stall_if(stall_if), .stall_id(stall_id), .bubble_ex(bubble_ex),
    .flush_id(flush_id), .stall_count(stall_count)
  );

  hazard_scoreboard #(.LAT_LOAD(1), .LAT_MUL(2), .CNT_W(4)) dut_small (
    .clk(clk), .rstn(rstn), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_class(id_class),
    .branch_taken_ex(branch_taken_ex), .freeze(freeze),
    .stall_if(s_stall_if), .stall_id(s_stall_id), .bubble_ex(s_bubble_ex),
    .flush_id(s_flush_id), .stall_count(s_stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_hazard();
    return id_valid &&
           ((id_use_rs1 && id_rs1 != 0 && mcnt[id_rs1] > 0) ||
            (id_use_rs2 && id_rs2 != 0 && mcnt[id_rs2] > 0));
  endfunction

  function automatic int m_lat(input logic [1:0] cls);
    if (cls == 2'b01) return 1;
    if (cls == 2'b10) return 2;
    return 0;
  endfunction

  // Model state advance on each rising edge
  always @(posedge clk) begin
    bit hz, iss;
    if (!rstn) begin
      for (int r = 0; r < 32; r++) mcnt[r] = 0;
      mcount = 0;
      mcount_small = 0;
    end else if (!freeze) begin
      hz  = m_hazard();
      iss = id_valid && !branch_taken_ex && !hz;
      for (int r = 1; r < 32; r++) if (mcnt[r] > 0) mcnt[r] = mcnt[r] - 1;
      if (iss && id_reg_write && id_rd != 0) mcnt[id_rd] = m_lat(id_class);
      if (hz && !branch_taken_ex) begin
        if (mcount < 65535) mcount = mcount + 1;
        if (mcount_small < 15) mcount_small = mcount_small + 1;
      end
    end
  end

  // Every-cycle comparison of both instances against the model
  always @(negedge clk) begin
    int e_si, e_bx, e_fl, e_ct, e_cs;
    e_si = 0; e_bx = 0; e_fl = 0; e_ct = 0; e_cs = 0;
    if (rstn) begin
      e_ct = mcount;
      e_cs = mcount_small;
      if (freeze) e_si = 1;
      else if (branch_taken_ex) begin e_fl = 1; e_bx = 1; end
      else if (m_hazard()) begin e_si = 1; e_bx = 1; end
    end
    chk("stall_if", stall_if, e_si);
    chk("stall_id", stall_id, e_si);
    chk("bubble_ex", bubble_ex, e_bx);
    chk("flush_id", flush_id, e_fl);
    chk("stall_count", stall_count, e_ct);
    chk("small_stall_id", s_stall_id, e_si);
    chk("small_stall_count", s_stall_count, e_cs);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic v, input logic [4:0] rs1, input logic u1,
                           input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                           input logic rw, input logic [1:0] cls);
    id_valid = v; id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2; id_use_rs2 = u2;
    id_rd = rd; id_reg_write = rw; id_class = cls;
  endtask

  task automatic idle();
    set_instr(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 2'b00);
    branch_taken_ex = 1'b0;
    freeze = 1'b0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    idle();
    tick();
    tick();
    rstn = 1'b1;
  endtask

  initial begin
    for (int r = 0; r < 32; r++) mcnt[r] = 0;
    mcount = 0;
    mcount_small = 0;
    rstn = 1'b0;
    idle();
    #1;
    chk("rst_stall_id", stall_id, 0);
    chk("rst_count", stall_count, 0);
    do_reset();

    // lw x5 ; add x6,x5,x1 -> one stall cycle
    set_instr(1, 5'd0, 0, 5'd0, 0, 5'd5, 1, 2'b01); #1;
    chk("lw_no_stall", stall_id, 0);
    tick();
    set_instr(1, 5'd5, 1, 5'd1, 1, 5'd6, 1, 2'b00); #1;
    chk("lu_stall", stall_id, 1);
    chk("lu_bubble", bubble_ex, 1);
    tick(); #1;
    chk("lu_issue", stall_id, 0);
    tick(); idle(); #1;
    chk("lu_count", stall_count, 1);

    // mul x7 ; sub x8,x7,x7 -> two stall cycles
    do_reset();
    set_instr(1, 5'd0, 0, 5'd0, 0, 5'd7, 1, 2'b10);
    tick();
    set_instr(1, 5'd7, 1, 5'd7, 1, 5'd8, 1, 2'b00); #1;
    chk("mul_stall1", stall_id, 1);
    tick(); #1;
    chk("mul_stall2", stall_id, 1);
    tick(); #1;
    chk("mul_issue", stall_id, 0);
    tick(); idle(); #1;
    chk("mul_count", stall_count, 2);

    // x0 never waits; unused rs2 never waits
    do_reset();
    set_instr(1, 5'd0, 0, 5'd0, 0, 5'd0, 1, 2'b01);
    tick();
    set_instr(1, 5'd0, 1, 5'd0, 1, 5'd3, 1, 2'b00); #1;
    chk("x0_no_stall", stall_id, 0);
    tick();
    set_instr(1, 5'd0, 0, 5'd0, 0, 5'd9, 1, 2'b01);
    tick();
    set_instr(1, 5'd2, 1, 5'd9, 0, 5'd4, 1, 2'b00); #1;
    chk("unused_rs2_no_stall", stall_id, 0);
    tick(); idle(); #1;
    chk("nostall_count", stall_count, 0);

    // Taken branch wins over hazard; squashed consumer never sets cnt
    do_reset();
    set_instr(1, 5'd0, 0, 5'd0, 0, 5'd5, 1, 2'b01);
    tick();
    set_instr(1, 5'd5, 1, 5'd0, 0, 5'd5, 1, 2'b01);
    branch_taken_ex = 1'b1; #1;
    chk("br_flush", flush_id, 1);
    chk("br_bubble", bubble_ex, 1);
    chk("br_stall", stall_id, 0);
    tick();
    branch_taken_ex = 1'b0;
    set_instr(1, 5'd5, 1, 5'd0, 0, 5'd6, 1, 2'b00); #1;
    chk("br_next_free", stall_id, 0);
    tick(); idle(); #1;
    chk("br_count", stall_count, 0);

    // Freeze on the stall cycle extends the stall; one hazard cycle remains
    do_reset();
    set_instr(1, 5'd0, 0, 5'd0, 0, 5'd5, 1, 2'b01);
    tick();
    set_instr(1, 5'd5, 1, 5'd1, 1, 5'd6, 1, 2'b00);
    freeze = 1'b1; #1;
    chk("frz_stall1", stall_id, 1);
    chk("frz_no_bubble", bubble_ex, 0);
    tick(); #1;
    chk("frz_stall2", stall_id, 1);
    tick(); #1;
    chk("frz_stall3", stall_id, 1);
    tick();
    freeze = 1'b0; #1;
    chk("frz_stall4", stall_id, 1);
    chk("frz_bubble4", bubble_ex, 1);
    tick(); #1;
    chk("frz_issue", stall_id, 0);
    tick(); idle(); #1;
    chk("frz_count", stall_count, 1);

    // Reset during a MUL stall releases the consumer
    do_reset();
    set_instr(1, 5'd0, 0, 5'd0, 0, 5'd7, 1, 2'b10);
    tick();
    set_instr(1, 5'd7, 1, 5'd7, 1, 5'd8, 1, 2'b00); #1;
    chk("rm_stall", stall_id, 1);
    tick();
    rstn = 1'b0; #1;
    chk("rm_forced_low", stall_id, 0);
    tick();
    rstn = 1'b1; #1;
    chk("rm_released", stall_id, 0);
    chk("rm_bubble", bubble_ex, 0);
    chk("rm_count", stall_count, 0);
    tick();

    // Chained mul x7,x7: 2 stalls per 3 cycles; narrow counter saturates
    do_reset();
    set_instr(1, 5'd7, 1, 5'd0, 0, 5'd7, 1, 2'b10);
    repeat (30) tick();
    idle(); #1;
    chk("chain_count", stall_count, 20);
    chk("chain_small_sat", s_stall_count, 15);

    // Randomized run, checked every cycle by the compare process
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      rstn            = ($urandom_range(0, 199) != 0);
      id_valid        = ($urandom_range(0, 3) != 0);
      id_rs1          = 5'($urandom_range(0, 7));
      id_rs2          = 5'($urandom_range(0, 7));
      id_use_rs1      = 1'($urandom_range(0, 1));
      id_use_rs2      = 1'($urandom_range(0, 1));
      id_rd           = 5'($urandom_range(0, 7));
      id_reg_write    = ($urandom_range(0, 3) != 0);
      id_class        = 2'($urandom_range(0, 3));
      branch_taken_ex = ($urandom_range(0, 9) == 0);
      freeze          = ($urandom_range(0, 7) == 0);
      tick();
    end
    rstn = 1'b1;
    idle();
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
